// File: rtl/vdp_pkg.sv
// Shared definitions for the VDP CPU front end: access codes, port FSM states,
// register count and CPU port selector values.
package vdp_pkg;
    localparam int NUM_REGS = 11;

    localparam logic PORT_DATA = 1'b0;
    localparam logic PORT_CTRL = 1'b1;

    typedef enum logic [1:0] {
        VRAM_RD = 2'd0,
        VRAM_WR = 2'd1,
        REG_WR  = 2'd2,
        CRAM_WR = 2'd3
    } vdp_code_t;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        RD_ISSUE   = 2'd1,
        RD_CAPTURE = 2'd2
    } port_state_t;
endpackage

// File: rtl/vdp_reg_file.sv
// VDP register bank: NUM_REGS bytes, single write port, packed parallel output.
// Writes addressed past the last register are dropped.
module vdp_reg_file #(
    parameter int NUM_REGS = vdp_pkg::NUM_REGS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we_i,
    input  logic [3:0]               idx_i,
    input  logic [7:0]               data_i,
    output logic [NUM_REGS-1:0][7:0] regs_o
);
    logic [NUM_REGS-1:0][7:0] regs_q;

    // register storage; the per-entry compare keeps out-of-range indices harmless
    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (we_i && (idx_i == 4'(i))) begin
                    regs_q[i] <= data_i;
                end
            end
        end
    end

    assign regs_o = regs_q;
endmodule

// File: rtl/vdp_cpu_port.sv
// VDP CPU port: decodes control/data port accesses into address/code setup,
// register writes, VRAM/CRAM writes and buffered VRAM reads.
module vdp_cpu_port #(
    parameter int VRAM_AW  = 14,
    parameter int CRAM_AW  = 5,
    parameter int CRAM_DW  = 6,
    parameter int NUM_REGS = vdp_pkg::NUM_REGS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cpu_req,
    input  logic                     cpu_we,
    input  logic                     cpu_port,
    input  logic [7:0]               cpu_wdata,
    output logic [7:0]               cpu_rdata,
    output logic                     cpu_ack,
    input  logic [7:0]               status_in,
    output logic                     status_clr,
    output logic [VRAM_AW-1:0]       vram_addr,
    output logic                     vram_we,
    output logic                     vram_re,
    output logic [7:0]               vram_wdata,
    input  logic [7:0]               vram_rdata,
    output logic [CRAM_AW-1:0]       cram_addr,
    output logic                     cram_we,
    output logic [CRAM_DW-1:0]       cram_wdata,
    output logic [NUM_REGS-1:0][7:0] regs
);
    import vdp_pkg::*;

    localparam logic [VRAM_AW-1:0] ADDR_ONE = VRAM_AW'(1);

    port_state_t        state_q, state_d;
    logic [VRAM_AW-1:0] addr_q, addr_d;
    vdp_code_t          code_q, code_d;
    logic               first_done_q, first_done_d;
    logic [7:0]         read_buf_q, read_buf_d;
    vdp_code_t          wcode_s;
    logic               accept_s;

    logic               ack_q, ack_d;
    logic [7:0]         rdata_q, rdata_d;
    logic               sclr_q, sclr_d;
    logic [VRAM_AW-1:0] vaddr_q, vaddr_d;
    logic               vwe_q, vwe_d;
    logic               vre_q, vre_d;
    logic [7:0]         vwdata_q, vwdata_d;
    logic [CRAM_AW-1:0] caddr_q, caddr_d;
    logic               cwe_q, cwe_d;
    logic [CRAM_DW-1:0] cwdata_q, cwdata_d;
    logic               reg_we_s;
    logic [3:0]         reg_idx_s;
    logic [7:0]         reg_data_s;

    // A request is not taken while its own ack is still showing.
    assign accept_s = (state_q == IDLE) && cpu_req && !ack_q;
    assign wcode_s  = vdp_code_t'(cpu_wdata[7:6]);

    // state and protocol registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            code_q       <= VRAM_RD;
            first_done_q <= 1'b0;
            read_buf_q   <= 8'h00;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            code_q       <= code_d;
            first_done_q <= first_done_d;
            read_buf_q   <= read_buf_d;
        end
    end

    // next-state and protocol decode
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        code_d       = code_q;
        first_done_d = first_done_q;
        read_buf_d   = read_buf_q;
        case (state_q)
            IDLE: begin
                if (!accept_s) begin
                    state_d = IDLE;
                end else if (cpu_port == PORT_CTRL) begin
                    first_done_d = 1'b0;
                    if (!cpu_we) begin
                        first_done_d = 1'b0;
                    end else if (!first_done_q) begin
                        addr_d[7:0]  = cpu_wdata;
                        first_done_d = 1'b1;
                    end else begin
                        addr_d[VRAM_AW-1:8] = cpu_wdata[VRAM_AW-9:0];
                        code_d              = wcode_s;
                        if (wcode_s == VRAM_RD) begin
                            state_d = RD_ISSUE;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end else begin
                    first_done_d = 1'b0;
                    if (cpu_we) begin
                        read_buf_d = cpu_wdata;
                        addr_d     = addr_q + ADDR_ONE;
                    end else begin
                        state_d = RD_ISSUE;
                    end
                end
            end
            RD_ISSUE: begin
                addr_d  = addr_q + ADDR_ONE;
                state_d = RD_CAPTURE;
            end
            RD_CAPTURE: begin
                read_buf_d = vram_rdata;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // next values of the registered outputs; strobes line up with the ack cycle
    always_comb begin
        ack_d      = accept_s;
        rdata_d    = rdata_q;
        sclr_d     = 1'b0;
        vaddr_d    = vaddr_q;
        vwe_d      = 1'b0;
        vre_d      = 1'b0;
        vwdata_d   = vwdata_q;
        caddr_d    = caddr_q;
        cwe_d      = 1'b0;
        cwdata_d   = cwdata_q;
        reg_we_s   = 1'b0;
        reg_idx_s  = cpu_wdata[3:0];
        reg_data_s = addr_q[7:0];
        if (accept_s) begin
            if (cpu_port == PORT_CTRL) begin
                if (!cpu_we) begin
                    rdata_d = status_in;
                    sclr_d  = 1'b1;
                end else if (first_done_q && (wcode_s == REG_WR)) begin
                    reg_we_s = 1'b1;
                end else begin
                    reg_we_s = 1'b0;
                end
            end else if (!cpu_we) begin
                rdata_d = read_buf_q;
            end else if (code_q == CRAM_WR) begin
                cwe_d    = 1'b1;
                caddr_d  = addr_q[CRAM_AW-1:0];
                cwdata_d = cpu_wdata[CRAM_DW-1:0];
            end else begin
                vwe_d    = 1'b1;
                vaddr_d  = addr_q;
                vwdata_d = cpu_wdata;
            end
        end else begin
            ack_d = 1'b0;
        end
        if (state_d == RD_ISSUE && state_q == IDLE) begin
            vre_d   = 1'b1;
            vaddr_d = addr_d;
        end else begin
            vre_d = vre_d;
        end
    end

    // output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q    <= 1'b0;
            rdata_q  <= 8'h00;
            sclr_q   <= 1'b0;
            vaddr_q  <= '0;
            vwe_q    <= 1'b0;
            vre_q    <= 1'b0;
            vwdata_q <= 8'h00;
            caddr_q  <= '0;
            cwe_q    <= 1'b0;
            cwdata_q <= '0;
        end else begin
            ack_q    <= ack_d;
            rdata_q  <= rdata_d;
            sclr_q   <= sclr_d;
            vaddr_q  <= vaddr_d;
            vwe_q    <= vwe_d;
            vre_q    <= vre_d;
            vwdata_q <= vwdata_d;
            caddr_q  <= caddr_d;
            cwe_q    <= cwe_d;
            cwdata_q <= cwdata_d;
        end
    end

    vdp_reg_file #(.NUM_REGS(NUM_REGS)) u_regs (
        .clk    (clk),
        .rst    (rst),
        .we_i   (reg_we_s),
        .idx_i  (reg_idx_s),
        .data_i (reg_data_s),
        .regs_o (regs)
    );

    assign cpu_ack    = ack_q;
    assign cpu_rdata  = rdata_q;
    assign status_clr = sclr_q;
    assign vram_addr  = vaddr_q;
    assign vram_we    = vwe_q;
    assign vram_re    = vre_q;
    assign vram_wdata = vwdata_q;
    assign cram_addr  = caddr_q;
    assign cram_we    = cwe_q;
    assign cram_wdata = cwdata_q;
endmodule
